// File: rtl/tern_pkg.sv
// Shared definitions for the ternary arithmetic blocks.
//   - Digit codes: 2-bit binary-coded ternary digit, 2'b11 is illegal.
//   - FSM state encoding for the digit-serial adder.
//   - clog2 helper for sizing counters.
package tern_pkg;

    localparam logic [1:0] TD_0   = 2'b00;
    localparam logic [1:0] TD_1   = 2'b01;
    localparam logic [1:0] TD_2   = 2'b10;
    localparam logic [1:0] TD_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } tern_state_e;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/ternary_full_adder_1digit.sv
// One-digit ternary full adder.
// Ports:
//   x, y  in  2  ternary digits (2'b00=0, 2'b01=1, 2'b10=2)
//   cin   in  1  binary carry in
//   s     out 2  ternary sum digit
//   cout  out 1  binary carry out
// Behaviour for illegal (2'b11) inputs is unspecified.
module ternary_full_adder_1digit
    import tern_pkg::*;
(
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout
);

    logic [2:0] total;

    always_comb begin
        total = {1'b0, x} + {1'b0, y} + {2'b00, cin};
        s     = TD_ILL;
        cout  = 1'b0;
        case (total)
            3'd0: begin s = TD_0; cout = 1'b0; end
            3'd1: begin s = TD_1; cout = 1'b0; end
            3'd2: begin s = TD_2; cout = 1'b0; end
            3'd3: begin s = TD_0; cout = 1'b1; end
            3'd4: begin s = TD_1; cout = 1'b1; end
            3'd5: begin s = TD_2; cout = 1'b1; end
            default: begin s = TD_ILL; cout = 1'b1; end
        endcase
    end

endmodule

// File: rtl/ternary_serial_adder.sv
// Digit-serial adder for N_DIGITS-digit unsigned ternary operands, LSD first.
// One digit is added per clock through a single ternary full-adder cell; the
// carry lives in a flop between digits.
// Ports:
//   clk    in   1           rising-edge clock
//   rst    in   1           synchronous active-high reset
//   start  in   1           request, accepted only in IDLE or DONE
//   a, b   in   2*N_DIGITS  operands, digit i = [2i+1:2i]
//   busy   out  1           high while in RUN
//   done   out  1           one-cycle pulse, sum/cout valid
//   sum    out  2*N_DIGITS  result digits
//   cout   out  1           carry out of the MSD
//   err    out  1           illegal-digit flag
// Optional feature: define TERN_ILLEGAL_CHECK_EN to flag 2'b11 operand digits
// at the start latch; otherwise err is tied low.
module ternary_serial_adder
    import tern_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*N_DIGITS-1:0] a,
    input  logic [2*N_DIGITS-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [2*N_DIGITS-1:0] sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W     = 2 * N_DIGITS;
    localparam int CNT_W = int'(clog2(N_DIGITS));

    tern_state_e state_q, state_d;

    logic [W-1:0]     a_sh_q, b_sh_q;
    logic [W-3:0]     sum_part_q, sum_part_d;  // digits 0..N-2 collected so far
    logic [W-1:0]     sum_q;
    logic             cout_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             last;
    logic [1:0]       cell_s;
    logic             cell_cout;

    ternary_full_adder_1digit u_cell (
        .x   (a_sh_q[1:0]),
        .y   (b_sh_q[1:0]),
        .cin (carry_q),
        .s   (cell_s),
        .cout(cell_cout)
    );

    assign last = (cnt_q == CNT_W'(N_DIGITS - 1));

    // New sum digits enter from the MSD side so digit 0 ends up at the bottom.
    if (N_DIGITS > 2) begin : g_wide
        assign sum_part_d = {cell_s, sum_part_q[W-3:2]};
    end else begin : g_narrow
        assign sum_part_d = cell_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            sum_part_q <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
        end else if (accept) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (state_q == ST_RUN) begin
            a_sh_q     <= {2'b00, a_sh_q[W-1:2]};
            b_sh_q     <= {2'b00, b_sh_q[W-1:2]};
            sum_part_q <= sum_part_d;
            carry_q    <= cell_cout;
            cnt_q      <= cnt_q + CNT_W'(1);
            if (last) begin
                sum_q  <= {cell_s, sum_part_q};
                cout_q <= cell_cout;
            end
        end
    end

`ifdef TERN_ILLEGAL_CHECK_EN
    logic err_q;
    logic has_illegal;

    always_comb begin
        has_illegal = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (a[2*i +: 2] == TD_ILL || b[2*i +: 2] == TD_ILL) begin
                has_illegal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= has_illegal;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_ternary_serial_adder.sv
// Self-checking bench for ternary_serial_adder (N_DIGITS = 4): directed cases
// plus random legal operands, compared against an integer-arithmetic model.
module tb_ternary_serial_adder;

    localparam int N_DIGITS = 4;
    localparam int W        = 2 * N_DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    ternary_serial_adder #(.N_DIGITS(N_DIGITS)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .err  (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decode both operands to integers, add, re-encode base 3.
    task automatic model_add(input logic [W-1:0] ma, input logic [W-1:0] mb,
                             output logic [W-1:0] ms, output logic mc);
        int va, vb, tot, mod, p;
        va = 0; vb = 0; p = 1;
        for (int i = 0; i < N_DIGITS; i++) begin
            va += int'(ma[2*i +: 2]) * p;
            vb += int'(mb[2*i +: 2]) * p;
            p  *= 3;
        end
        mod = p;
        tot = va + vb;
        mc  = (tot >= mod);
        tot = tot % mod;
        ms  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            ms[2*i +: 2] = 2'(tot % 3);
            tot = tot / 3;
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        for (int i = 0; i < N_DIGITS; i++) v[2*i +: 2] = 2'($urandom_range(0, 2));
        return v;
    endfunction

    int last_done_cyc;

    // Launch an add, scramble operands during RUN, optionally pulse start on
    // RUN cycle `poke`, then check latency and result. Leaves the bench at the
    // DONE cycle so a following call exercises back-to-back acceptance.
    task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input int poke, input string tag);
        logic [W-1:0] es;
        logic         ec;
        int           cycles;
        model_add(ta, tb, es, ec);
        a = ta; b = tb; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 0;
        while (busy && cycles < 20) begin
            cycles++;
            start = (cycles == poke);
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_eq({tag, "_busy_cycles"}, 32'(cycles), 32'(N_DIGITS));
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_sum"}, 32'(sum), 32'(es));
        check_eq({tag, "_cout"}, 32'(cout), 32'(ec));
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        last_done_cyc = cyc;
    endtask

    initial begin
        int first_done, pulses;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_cout", 32'(cout), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic add and the full carry ripple.
        do_add(8'h49, 8'h16, 0, "case1");
        check_eq("case1_sum_const", 32'(sum), 32'h64);
        @(posedge clk); #1;
        check_eq("case1_done_drop", 32'(done), 32'd0);
        do_add(8'hAA, 8'h01, 0, "case2");
        check_eq("case2_sum_const", 32'(sum), 32'h00);
        check_eq("case2_cout_const", 32'(cout), 32'd1);
        @(posedge clk); #1;

        // Back-to-back: start held in DONE.
        do_add(8'h49, 8'h16, 0, "b2b_a");
        first_done = last_done_cyc;
        do_add(8'h00, 8'h00, 0, "b2b_b");
        check_eq("b2b_gap", 32'(last_done_cyc - first_done), 32'd5);
        @(posedge clk); #1;

        // Start during RUN is ignored.
        do_add(8'h49, 8'h16, 2, "poke");
        @(posedge clk); #1;

        // Reset on the 2nd RUN cycle aborts with no done pulse.
        a = 8'h49; b = 8'h16; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_sum", 32'(sum), 32'd0);
        check_eq("abort_cout", 32'(cout), 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        check_eq("abort_no_done", 32'(pulses), 32'd0);
        do_add(8'h49, 8'h16, 0, "after_abort");
        @(posedge clk); #1;

        // Illegal-digit flag.
        a = 8'h03; b = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef TERN_ILLEGAL_CHECK_EN
        check_eq("err_set", 32'(err), 32'd1);
`else
        check_eq("err_tied", 32'(err), 32'd0);
`endif
        pulses = 0;
        while (!done && pulses < 20) begin
            pulses++;
            @(posedge clk); #1;
        end
        check_eq("err_run_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        do_add(8'h12, 8'h21, 0, "err_clear");
        @(posedge clk); #1;

        // Random legal operands, mixing idle gaps and back-to-back starts.
        for (int i = 0; i < 40; i++) begin
            do_add(rand_operand(), rand_operand(), int'($urandom_range(0, 5)), "rand");
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
